// File: rtl/down_timer_if.sv
// down_timer_if: control and status bundle between a timer client and the down_timer
interface down_timer_if #(parameter int WIDTH = 8);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             reload_mode;
  logic             abort;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  modport master (output load, load_value, enable, reload_mode, abort, input out, busy, done);
  modport slave  (input load, load_value, enable, reload_mode, abort, output out, busy, done);
endinterface

// File: rtl/down_timer.sv
// down_timer: loadable down-counter with one-shot / auto-reload expiry pulse
module down_timer #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  down_timer_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]       state;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] out;
  logic             done;
  assign bus.out  = out;
  assign bus.busy = state == RUN;
  assign bus.done = done;
  // abort beats load beats counting; done is a single-cycle pulse on the expiry edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out        <= '0;
      reload_reg <= '0;
      state      <= IDLE;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.abort) begin
        out   <= '0;
        state <= IDLE;
      end else if (bus.load) begin
        out        <= bus.load_value;
        reload_reg <= bus.load_value;
        state      <= bus.load_value != '0 ? RUN : IDLE;
      end else if (state == RUN && bus.enable) begin
        if (out == WIDTH'(1)) begin
          done  <= 1'b1;
          out   <= bus.reload_mode ? reload_reg : '0;
          state <= bus.reload_mode ? RUN : IDLE;
        end else begin
          out <= out - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed self-checking bench for down_timer
module tb_down_timer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  down_timer_if #(.WIDTH(8)) bus();
  down_timer #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [7:0] lv, input logic en, input logic rm, input logic ab);
    bus.load = ld;
    bus.load_value = lv;
    bus.enable = en;
    bus.reload_mode = rm;
    bus.abort = ab;
  endtask

  task automatic test_reset;
    drive(1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
    tick;
    bus.load = 1'b0;
    tick;
    tick;
    checks++;
    if ({bus.out, bus.busy, bus.done} !== {8'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_pre: out=%0d busy=%b done=%b, expected out=3 busy=1 done=0", bus.out, bus.busy, bus.done);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.out, bus.busy, bus.done} !== {8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async: out=%0d busy=%b done=%b, expected out=0 busy=0 done=0", bus.out, bus.busy, bus.done);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if ({bus.out, bus.busy, bus.done} !== {8'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_after[%0d]: out=%0d busy=%b done=%b, expected 0/0/0", i, bus.out, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_oneshot;
    drive(1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
    tick;
    bus.load = 1'b0;
    checks++;
    if ({bus.out, bus.busy, bus.done} !== {8'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL oneshot_load: out=%0d busy=%b done=%b, expected 5/1/0", bus.out, bus.busy, bus.done);
    end
    for (int i = 4; i >= 0; i--) begin
      logic [7:0] e = 8'(i);
      tick;
      checks++;
      if ({bus.out, bus.busy, bus.done} !== {e, i != 0, i == 0}) begin
        errors++;
        $display("FAIL oneshot_count: out=%0d busy=%b done=%b, expected %0d/%b/%b", bus.out, bus.busy, bus.done, e, i != 0, i == 0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({bus.out, bus.busy, bus.done} !== {8'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL oneshot_hold: out=%0d busy=%b done=%b, expected 0/0/0", bus.out, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_reload;
    drive(1'b1, 8'd3, 1'b1, 1'b1, 1'b0);
    tick;
    bus.load = 1'b0;
    checks++;
    if ({bus.out, bus.busy, bus.done} !== {8'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reload_load: out=%0d busy=%b done=%b, expected 3/1/0", bus.out, bus.busy, bus.done);
    end
    for (int k = 1; k <= 10; k++) begin
      logic [7:0] e = (k % 3 == 0) ? 8'd3 : 8'(3 - k % 3);
      tick;
      checks++;
      if ({bus.out, bus.busy, bus.done} !== {e, 1'b1, k % 3 == 0}) begin
        errors++;
        $display("FAIL reload_edge%0d: out=%0d busy=%b done=%b, expected %0d/1/%b", k, bus.out, bus.busy, bus.done, e, k % 3 == 0);
      end
    end
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    tick;
    bus.abort = 1'b0;
  endtask

  task automatic test_enable_gating;
    logic [5:0] en_pat = 6'b111001;
    logic [7:0] exp_out [6] = '{8'd3, 8'd3, 8'd3, 8'd2, 8'd1, 8'd0};
    int first_done;
    drive(1'b1, 8'd4, 1'b1, 1'b0, 1'b0);
    tick;
    bus.load = 1'b0;
    checks++;
    if (bus.out !== 8'd4) begin
      errors++;
      $display("FAIL gate_load: out=%0d, expected 4", bus.out);
    end
    for (int i = 0; i < 6; i++) begin
      bus.enable = en_pat[i];
      tick;
      checks++;
      if ({bus.out, bus.busy, bus.done} !== {exp_out[i], i != 5, i == 5}) begin
        errors++;
        $display("FAIL gate_step%0d: out=%0d busy=%b done=%b, expected %0d/%b/%b", i, bus.out, bus.busy, bus.done, exp_out[i], i != 5, i == 5);
      end
    end
    drive(1'b1, 8'd255, 1'b1, 1'b0, 1'b0);
    tick;
    bus.load = 1'b0;
    first_done = 0;
    for (int i = 1; i <= 260; i++) begin
      tick;
      if (i == 254) begin
        checks++;
        if (bus.out !== 8'd1) begin
          errors++;
          $display("FAIL max_pre: out=%0d, expected 1", bus.out);
        end
      end
      if (bus.done === 1'b1 && first_done == 0) first_done = i;
    end
    checks++;
    if (first_done != 255) begin
      errors++;
      $display("FAIL max_done_edge: done first seen on edge %0d, expected 255", first_done);
    end
  endtask

  task automatic test_load_zero;
    drive(1'b1, 8'd0, 1'b1, 1'b1, 1'b0);
    tick;
    bus.load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.out, bus.busy, bus.done} !== {8'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL load_zero[%0d]: out=%0d busy=%b done=%b, expected 0/0/0", i, bus.out, bus.busy, bus.done);
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
    tick;
    bus.load = 1'b0;
    tick;
    checks++;
    if ({bus.out, bus.busy} !== {8'd1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_pre: out=%0d busy=%b, expected 1/1", bus.out, bus.busy);
    end
    drive(1'b1, 8'd7, 1'b1, 1'b0, 1'b0);
    tick;
    bus.load = 1'b0;
    checks++;
    if ({bus.out, bus.busy, bus.done} !== {8'd7, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_reload: out=%0d busy=%b done=%b, expected 7/1/0", bus.out, bus.busy, bus.done);
    end
    tick;
    tick;
    tick;
    checks++;
    if (bus.out !== 8'd4) begin
      errors++;
      $display("FAIL b2b_count: out=%0d, expected 4", bus.out);
    end
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.out, bus.busy, bus.done} !== {8'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL abort[%0d]: out=%0d busy=%b done=%b, expected 0/0/0", i, bus.out, bus.busy, bus.done);
      end
      tick;
    end
    drive(1'b1, 8'd9, 1'b1, 1'b0, 1'b0);
    tick;
    drive(1'b1, 8'd6, 1'b1, 1'b0, 1'b1);
    tick;
    drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({bus.out, bus.busy, bus.done} !== {8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_vs_load: out=%0d busy=%b done=%b, expected 0/0/0", bus.out, bus.busy, bus.done);
    end
    tick;
    checks++;
    if ({bus.out, bus.busy} !== {8'd0, 1'b0}) begin
      errors++;
      $display("FAIL abort_vs_load_hold: out=%0d busy=%b, expected 0/0", bus.out, bus.busy);
    end
  endtask

  initial begin
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    #12;
    checks++;
    if ({bus.out, bus.busy, bus.done} !== {8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: out=%0d busy=%b done=%b, expected 0/0/0", bus.out, bus.busy, bus.done);
    end
    @(negedge clk);
    reset = 1'b0;
    test_reset;
    test_oneshot;
    test_reload;
    test_enable_gating;
    test_load_zero;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
